zero_cross_emulator: RTL

- Mains-side counterpart to the phase-control firing block.
- Generates the `sinc` zero-crossing square wave that the firing block consumes: one toggle per mains half cycle, at a programmable half-period.
- Receives the firing block's `ctr1` pulse and measures, per half cycle, the delay from the zero crossing to the pulse and the pulse width, in clk cycles.
- Used as an on-chip mains emulator for bring-up and as a loop-back checker.

---
 rtl/zce_pkg.sv | 17 +
 rtl/zce_edge_detect.sv | 37 +++
 rtl/zero_cross_emulator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/zce_pkg.sv
// Shared types and constants for the zero-crossing emulator.
package zce_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_PULSE = 2'd1,
      IN_PULSE   = 2'd2,
      DONE       = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_NO_PULSE = 2'd1;
   localparam logic [1:0] ERR_OVERRUN  = 2'd2;

   localparam int unsigned HALF_PERIOD_MIN = 2;

endpackage

// File: rtl/zce_edge_detect.sv
// ctr1 rise/fall detector; ZCE_CTR1_SYNC_EN inserts a 2-flop synchronizer in front.
// Edges are flagged in the cycle the (synchronized) level first differs from its registered copy.
module zce_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ctr1_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic lvl;
   logic ctr1_d_q;

`ifdef ZCE_CTR1_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], ctr1_i};
   end

   assign lvl = sync_q[1];
`else
   assign lvl = ctr1_i;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ctr1_d_q <= 1'b0;
      else       ctr1_d_q <= lvl;
   end

   assign lvl_o  = lvl;
   assign rise_o = lvl & ~ctr1_d_q;
   assign fall_o = ~lvl & ctr1_d_q;

endmodule

// File: rtl/zero_cross_emulator.sv
// Mains emulator: drives the sinc square wave and measures ctr1 delay/width per half cycle.
// Build with ZCE_CTR1_SYNC_EN to synchronize ctr1 before edge detection (delays grow by 2).
module zero_cross_emulator
   import zce_pkg::*;
#(
   parameter int unsigned CNT_W           = 18,
   parameter int unsigned HALF_PERIOD_DEF = 225000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] half_period,
   input  logic             ctr1,
   output logic             sinc,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_delay,
   output logic [CNT_W-1:0] meas_width,
   output logic [1:0]       meas_err
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] ph_q, ph_d;
   logic [CNT_W-1:0] hp_q, hp_d;
   logic             sinc_q, sinc_d;
   logic [CNT_W-1:0] delay_q, delay_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             mv_q, mv_d;
   logic [CNT_W-1:0] md_q, md_d;
   logic [CNT_W-1:0] mw_q, mw_d;
   logic [1:0]       me_q, me_d;

   logic             lvl, rise, fall;
   logic             wrap;
   logic [CNT_W-1:0] hp_clamp;

   zce_edge_detect u_edge (
      .clk_i  (clk),
      .rst_i  (rst),
      .ctr1_i (ctr1),
      .lvl_o  (lvl),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign hp_clamp = (half_period < CNT_W'(HALF_PERIOD_MIN)) ? CNT_W'(HALF_PERIOD_MIN) : half_period;
   assign wrap     = (ph_q == hp_q - CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ph_q    <= '0;
         hp_q    <= CNT_W'(HALF_PERIOD_DEF);
         sinc_q  <= 1'b0;
         delay_q <= '0;
         width_q <= '0;
         mv_q    <= 1'b0;
         md_q    <= '0;
         mw_q    <= '0;
         me_q    <= ERR_OK;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         hp_q    <= hp_d;
         sinc_q  <= sinc_d;
         delay_q <= delay_d;
         width_q <= width_d;
         mv_q    <= mv_d;
         md_q    <= md_d;
         mw_q    <= mw_d;
         me_q    <= me_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      hp_d    = hp_q;
      sinc_d  = sinc_q;
      delay_d = delay_q;
      width_d = width_q;
      mv_d    = 1'b0;
      md_d    = md_q;
      mw_d    = mw_q;
      me_d    = me_q;

      if (!en) begin
         state_d = IDLE;
      end else if (state_q == IDLE) begin
         // Restart the mains phase without toggling sinc.
         ph_d    = '0;
         hp_d    = hp_clamp;
         state_d = WAIT_PULSE;
      end else begin
         if (wrap) begin
            ph_d   = '0;
            sinc_d = ~sinc_q;
            hp_d   = hp_clamp;
         end else begin
            ph_d = ph_q + CNT_W'(1);
         end

         case (state_q)
            WAIT_PULSE: begin
               if (rise) begin
                  delay_d = ph_q;
                  width_d = CNT_W'(1);
                  state_d = IN_PULSE;
               end
            end
            IN_PULSE: begin
               if (fall) begin
                  mv_d    = 1'b1;
                  md_d    = delay_q;
                  mw_d    = width_q;
                  me_d    = ERR_OK;
                  state_d = DONE;
               end else if (lvl && (width_q != '1)) begin
                  width_d = width_q + CNT_W'(1);
               end
            end
            default: ;
         endcase

         // Wrap resolution sees the post-edge state so a same-cycle rise counts as OVERRUN.
         if (wrap) begin
            case (state_d)
               WAIT_PULSE: begin
                  mv_d = 1'b1;
                  md_d = '0;
                  mw_d = '0;
                  me_d = ERR_NO_PULSE;
               end
               IN_PULSE: begin
                  mv_d    = 1'b1;
                  md_d    = delay_d;
                  mw_d    = width_d;
                  me_d    = ERR_OVERRUN;
                  delay_d = '0;
                  width_d = '0;
               end
               default: state_d = WAIT_PULSE;
            endcase
         end
      end
   end

   always_comb begin
      sinc       = sinc_q;
      meas_valid = mv_q;
      meas_delay = md_q;
      meas_width = mw_q;
      meas_err   = me_q;
   end

endmodule
